// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per clock, with sign correction in a final commit state.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             cancel,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [CW-1:0]    r_count;
    // r_upper:r_lower is the product / remainder:quotient pair; r_operand is the
    // multiplicand (MUL*) or divisor (DIV*).
    logic [WIDTH-1:0] r_upper;
    logic [WIDTH-1:0] r_lower;
    logic [WIDTH-1:0] r_operand;
    logic             r_is_div;
    logic             r_neg_a;
    logic             r_neg_b;
    logic             r_dbz_pend;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_dbz;

    logic             w_accept;
    logic             w_iter;
    logic             w_commit;

    logic             w_signed_op;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_start_dbz;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_upper;
    logic [WIDTH-1:0] w_mul_lower;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_upper;
    logic [WIDTH-1:0] w_div_lower;
    logic [WIDTH-1:0] w_upper_step;
    logic [WIDTH-1:0] w_lower_step;

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // Operand conditioning at acceptance: MULT (00) and DIV (10) are the signed ops.
    assign w_signed_op = ~op[0];
    assign w_neg_a     = w_signed_op & opa[WIDTH-1];
    assign w_neg_b     = w_signed_op & opb[WIDTH-1];
    assign w_mag_a     = w_neg_a ? -opa : opa;
    assign w_mag_b     = w_neg_b ? -opb : opb;
    assign w_start_dbz = op[1] & (opb == '0);

    // Multiply step: conditionally add multiplicand to the upper half, shift right.
    assign w_mul_sum   = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_operand} : {(WIDTH+1){1'b0}});
    assign w_mul_upper = w_mul_sum[WIDTH:1];
    assign w_mul_lower = {w_mul_sum[0], r_lower[WIDTH-1:1]};

    // Divide step: shift in the next dividend bit, subtract if it fits (bit WIDTH is the borrow).
    assign w_div_shift = {r_upper, r_lower[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_operand};
    assign w_div_ge    = ~w_div_diff[WIDTH];
    assign w_div_upper = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_div_lower = {r_lower[WIDTH-2:0], w_div_ge};

    assign w_upper_step = r_is_div ? w_div_upper : w_mul_upper;
    assign w_lower_step = r_is_div ? w_div_lower : w_mul_lower;

    // Sign correction. On divide-by-zero r_upper holds |opa|, so the remainder
    // fix-up restores the original dividend for HI.
    assign w_prod     = {r_upper, r_lower};
    assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
    assign w_quot_fix = (r_neg_a ^ r_neg_b) ? -r_lower : r_lower;
    assign w_rem_fix  = r_neg_a ? -r_upper : r_upper;
    assign w_res_hi   = r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_res_lo   = r_is_div ? (r_dbz_pend ? {WIDTH{1'b1}} : w_quot_fix)
                                 : w_prod_fix[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_iter       = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !cancel) begin
                    w_accept     = 1'b1;
                    w_state_next = w_start_dbz ? FIX : CALC;
                end
            end
            CALC: begin
                if (cancel) begin
                    w_state_next = IDLE;
                end else begin
                    w_iter = 1'b1;
                    if (r_count == CW'(WIDTH - 1)) begin
                        w_state_next = FIX;
                    end
                end
            end
            FIX: begin
                w_state_next = IDLE;
                if (!cancel) begin
                    w_commit = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_upper    <= '0;
            r_lower    <= '0;
            r_operand  <= '0;
            r_is_div   <= 1'b0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_is_div   <= op[1];
                r_neg_a    <= w_neg_a;
                r_neg_b    <= w_neg_b;
                r_dbz_pend <= w_start_dbz;
                r_count    <= '0;
                if (w_start_dbz) begin
                    r_upper <= w_mag_a;
                    r_lower <= {WIDTH{1'b1}};
                end else if (op[1]) begin
                    r_upper   <= '0;
                    r_lower   <= w_mag_a;
                    r_operand <= w_mag_b;
                end else begin
                    r_upper   <= '0;
                    r_lower   <= w_mag_b;
                    r_operand <= w_mag_a;
                end
            end else if (w_iter) begin
                r_upper <= w_upper_step;
                r_lower <= w_lower_step;
                r_count <= r_count + 1'b1;
            end

            // Direct writes land first; a same-cycle start commits over them later.
            if (r_state == IDLE) begin
                if (wr_hi) begin
                    r_hi <= wr_data;
                end
                if (wr_lo) begin
                    r_lo <= wr_data;
                end
            end

            if (w_commit) begin
                r_hi   <= w_res_hi;
                r_lo   <= w_res_lo;
                r_dbz  <= r_dbz_pend;
                r_done <= 1'b1;
            end
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized + directed bench for muldiv_unit against a transaction-level arithmetic model.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         cancel;
    logic         wr_hi;
    logic         wr_lo;
    logic [W-1:0] wr_data;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .opa         (opa),
        .opb         (opb),
        .cancel      (cancel),
        .wr_hi       (wr_hi),
        .wr_lo       (wr_lo),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    bit         m_dbz  = 1'b0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int         m_left = 0;
    logic [W-1:0] m_res_hi;
    logic [W-1:0] m_res_lo;
    bit         m_res_dbz;

    task automatic compute(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] rh, output logic [W-1:0] rl, output bit z);
        longint sa;
        longint sb;
        longint sp;
        longint sq;
        longint sr;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        z  = 1'b0;
        case (o)
            2'b00: begin
                sp = sa * sb;
                rh = sp[63:32];
                rl = sp[31:0];
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                rh = up[63:32];
                rl = up[31:0];
            end
            default: begin
                if (b == '0) begin
                    rh = a;
                    rl = '1;
                    z  = 1'b1;
                end else if (o == 2'b10) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    rh = sr[31:0];
                    rl = sq[31:0];
                end else begin
                    rh = a % b;
                    rl = a / b;
                end
            end
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_dbz  = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
            m_left = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (wr_hi) m_hi = wr_data;
                if (wr_lo) m_lo = wr_data;
                if (start && !cancel) begin
                    compute(op, opa, opb, m_res_hi, m_res_lo, m_res_dbz);
                    m_busy = 1'b1;
                    m_left = m_res_dbz ? 1 : W + 1;
                end
            end else if (cancel) begin
                m_busy = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_hi   = m_res_hi;
                    m_lo   = m_res_lo;
                    m_dbz  = m_res_dbz;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", {63'd0, busy}, {63'd0, m_busy});
            chk("cyc_done", {63'd0, done}, {63'd0, m_done});
            chk("cyc_dbz", {63'd0, div_by_zero}, {63'd0, m_dbz});
            chk("cyc_hi", {32'd0, hi}, {32'd0, m_hi});
            chk("cyc_lo", {32'd0, lo}, {32'd0, m_lo});
        end
    end

    // Issue one op from the drive phase; returns start-edge-to-done latency and busy cycles.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int bcnt);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        @(negedge clk);
        if (busy) bcnt++;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return W'($urandom_range(0, 20));
            4: return 32'h7FFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    int lat;
    int bcnt;
    int done_seen;

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        opa     = '0;
        opb     = '0;
        cancel  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        wr_data = '0;

        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First start right after reset release; full-width unsigned product.
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        chk("multu_latency", 64'(lat), 64'd33);
        chk("multu_busy_cycles", 64'(bcnt), 64'd33);
        chk("multu_hi", {32'd0, hi}, 64'hFFFF_FFFE);
        chk("multu_lo", {32'd0, lo}, 64'h0000_0001);
        chk("model_multu_hi", {32'd0, m_hi}, 64'hFFFF_FFFE);

        do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, lat, bcnt);
        chk("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        chk("mult_lo", {32'd0, lo}, 64'hFFFF_FFF1);
        chk("model_mult_lo", {32'd0, m_lo}, 64'hFFFF_FFF1);

        do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, lat, bcnt);
        chk("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        chk("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        chk("model_div_hi", {32'd0, m_hi}, 64'hFFFF_FFFF);

        do_op(2'b11, 32'h0000_0064, 32'h0000_0000, lat, bcnt);
        chk("dbz_latency", 64'(lat), 64'd1);
        chk("dbz_hi", {32'd0, hi}, 64'h0000_0064);
        chk("dbz_lo", {32'd0, lo}, 64'hFFFF_FFFF);
        chk("dbz_flag", {63'd0, div_by_zero}, 64'd1);

        do_op(2'b11, 32'h0000_0064, 32'h0000_0007, lat, bcnt);
        chk("divu_lo", {32'd0, lo}, 64'h0000_000E);
        chk("divu_hi", {32'd0, hi}, 64'h0000_0002);
        chk("divu_flag", {63'd0, div_by_zero}, 64'd0);

        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        chk("divovf_lo", {32'd0, lo}, 64'h8000_0000);
        chk("divovf_hi", {32'd0, hi}, 64'h0000_0000);
        chk("divovf_flag", {63'd0, div_by_zero}, 64'd0);
        chk("model_divovf_lo", {32'd0, m_lo}, 64'h8000_0000);

        // MTHI, then a MULTU that is hit by a stray start and then cancelled.
        wr_hi   = 1'b1;
        wr_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        wr_hi  = 1'b0;
        start  = 1'b1;
        op     = 2'b01;
        opa    = 32'd2;
        opb    = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        opa   = 32'd7;
        opb   = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(negedge clk);
        chk("cancel_busy_before", {63'd0, busy}, 64'd1);
        @(posedge clk);
        #1;
        cancel = 1'b0;
        @(negedge clk);
        chk("cancel_busy_after", {63'd0, busy}, 64'd0);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("cancel_no_done", 64'(done_seen), 64'd0);
        chk("cancel_hi", {32'd0, hi}, 64'h1234_5678);
        chk("cancel_lo", {32'd0, lo}, 64'h8000_0000);
        @(posedge clk);
        #1;

        // Cancel beats start in IDLE.
        start  = 1'b1;
        cancel = 1'b1;
        op     = 2'b00;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        @(negedge clk);
        chk("cancel_start_idle", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;

        // MTHI and MTLO together.
        wr_hi   = 1'b1;
        wr_lo   = 1'b1;
        wr_data = 32'hA5A5_5A5A;
        @(posedge clk);
        #1;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        chk("wr_both_hi", {32'd0, hi}, 64'hA5A5_5A5A);
        chk("wr_both_lo", {32'd0, lo}, 64'hA5A5_5A5A);

        // Asynchronous reset in the middle of CALC.
        start = 1'b1;
        op    = 2'b01;
        opa   = 32'd3;
        opb   = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_hi", {32'd0, hi}, 64'd0);
        chk("arst_lo", {32'd0, lo}, 64'd0);
        chk("arst_dbz", {63'd0, div_by_zero}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("arst_no_done", 64'(done_seen), 64'd0);
        @(posedge clk);
        #1;

        // Randomized traffic checked cycle-by-cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            start   = ($urandom_range(0, 3) == 0);
            op      = 2'($urandom_range(0, 3));
            opa     = rand_operand();
            opb     = rand_operand();
            cancel  = ($urandom_range(0, 59) == 0);
            wr_hi   = ($urandom_range(0, 9) == 0);
            wr_lo   = ($urandom_range(0, 9) == 0);
            wr_data = W'($urandom);
            @(posedge clk);
            #1;
        end
        start  = 1'b0;
        cancel = 1'b0;
        wr_hi  = 1'b0;
        wr_lo  = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width (even, >=4).
REQ-002 SHALL provide port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL provide port op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
REQ-006 SHALL provide ports opa, opb  input  WIDTH  operands (dividend/divisor for DIV*), sampled with start.
REQ-007 SHALL provide port cancel  input  1  abort in-flight operation.
REQ-008 SHALL provide ports wr_hi, wr_lo  input  1  direct HI/LO write enables (MTHI/MTLO).
REQ-009 SHALL provide port wr_data  input  WIDTH  data for wr_hi/wr_lo.
REQ-010 SHALL provide port busy  output  1  high while not IDLE.
REQ-011 SHALL provide port done  output  1  one-cycle pulse on result commit.
REQ-012 SHALL provide port div_by_zero  output  1  sticky flag of last completed operation.
REQ-013 SHALL provide ports hi, lo  output  WIDTH  registered HI/LO contents.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX; counter wide enough to hold WIDTH.
REQ-015 IDLE with start=1 and cancel=0 at edge E0 SHALL latch op, operand magnitudes (signed ops: two's-complement absolute value), operand signs, go to CALC, counter=0.
REQ-016 CALC SHALL perform one iteration per edge: MUL* radix-2 shift-add of 2*WIDTH product; DIV* restoring shift-subtract producing one quotient bit.
REQ-017 CALC SHALL go to FIX after WIDTH iterations (edges E1..E_WIDTH).
REQ-018 FIX at edge E_WIDTH+1 SHALL apply sign correction, write hi/lo, pulse done, return to IDLE; latency start-edge to done-high = WIDTH+1 cycles (33 for WIDTH=32).
REQ-019 MUL* SHALL set {hi,lo} = full 2*WIDTH product; MULT negates product when sign(opa)^sign(opb).
REQ-020 DIV* SHALL set lo=quotient, hi=remainder; DIV quotient negative iff signs differ, remainder takes sign of dividend (truncating division).
REQ-021 DIV with opa=most-negative, opb=-1 SHALL give lo=most-negative, hi=0, div_by_zero=0.
REQ-022 DIV*/opb=0 at start SHALL skip CALC: FIX at E1 sets hi=opa, lo=all-ones, div_by_zero=1, done pulse; latency 1 cycle.
REQ-023 div_by_zero SHALL update only on done (1 on divide-by-zero, else 0).
REQ-024 start while busy SHALL be ignored; operands not re-sampled.
REQ-025 cancel while busy SHALL return to IDLE next edge; no done; hi, lo, div_by_zero unchanged.
REQ-026 cancel and start both high in IDLE SHALL leave block IDLE (cancel wins).
REQ-027 wr_hi/wr_lo in IDLE SHALL load wr_data into hi/lo next edge; both may be set together.
REQ-028 wr_hi/wr_lo while busy SHALL be ignored.
REQ-029 wr_hi/wr_lo and start in same IDLE cycle SHALL apply the write and start; final result overwrites at FIX.
REQ-030 hi/lo SHALL hold value between commits; no intermediate values visible.

Reset
REQ-031 rst=1 SHALL immediately, independent of clk, force IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
REQ-032 rst asserted mid-operation SHALL discard operation; no done after release.
REQ-033 first start SHALL be accepted on first rising edge after rst deasserts.

Verification
REQ-034 MULTU opa=FFFFFFFF opb=FFFFFFFF -> done 33 cycles after start, hi=FFFFFFFE, lo=00000001, busy high 33 cycles.
REQ-035 MULT opa=FFFFFFFD(-3) opb=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1; DIV opa=FFFFFFF9(-7) opb=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-036 DIVU opa=00000064 opb=0 -> done 1 cycle later, hi=00000064, lo=FFFFFFFF, div_by_zero=1; next DIVU 100/7 -> lo=0000000E, hi=00000002, div_by_zero=0.
REQ-037 DIV opa=80000000 opb=FFFFFFFF -> lo=80000000, hi=00000000, div_by_zero=0.
REQ-038 wr_hi=1 wr_data=12345678 in IDLE, then MULTU 2*3 with cancel at cycle 10 and extra start at cycle 5 -> no done, hi=12345678, lo unchanged, busy low cycle 11.
REQ-039 rst pulse mid-CALC (asynchronous, between edges) -> busy, done, hi, lo drop to 0 immediately; no done afterwards.
